// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tmds_decoder
// Description : TMDS lane decoder. Recovers 8-bit pixel data, 2-bit control
//               and data-enable from 10-bit symbols, and hunts for word
//               alignment by requesting bitslips until control tokens line up.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder #(
    parameter int SEARCH_WINDOW = 4096,
    parameter int LOCK_TOKENS   = 8,
    parameter int SLIP_WAIT     = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [9:0] sym_i,
    input  logic       sym_valid_i,
    output logic [7:0] data_o,
    output logic [1:0] ctrl_o,
    output logic       de_o,
    output logic       valid_o,
    output logic       locked_o,
    output logic       bitslip_o,
    output logic       lock_lost_o
);

    localparam int c_WIN_W  = $clog2(SEARCH_WINDOW + 1);
    localparam int c_SLIP_W = $clog2(SLIP_WAIT + 1);

    localparam logic [c_WIN_W-1:0]  c_WIN_LIM   = c_WIN_W'(SEARCH_WINDOW);
    localparam logic [c_SLIP_W-1:0] c_SLIP_LAST = c_SLIP_W'(SLIP_WAIT - 1);
    localparam logic [7:0]          c_LOCK_LIM  = 8'(LOCK_TOKENS);
    localparam logic [7:0]          c_BLANK_MIN = 8'd2;

    localparam logic [1:0] c_ST_SEARCH = 2'd0;
    localparam logic [1:0] c_ST_SLIP   = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    // ------------------------------------------------------------------------
    // Control token detection (shared by the datapath and the alignment FSM)
    // ------------------------------------------------------------------------
    logic       w_is_ctrl;
    logic [1:0] w_ctrl;

    always_comb begin
        w_is_ctrl = 1'b1;
        w_ctrl    = 2'b00;
        case (sym_i)
            10'h354: w_ctrl = 2'b00;
            10'h0AB: w_ctrl = 2'b01;
            10'h154: w_ctrl = 2'b10;
            10'h2AB: w_ctrl = 2'b11;
            default: w_is_ctrl = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Stage 1: token classification and conditional inversion
    // ------------------------------------------------------------------------
    logic       r_s1_valid;
    logic       r_s1_is_ctrl;
    logic [1:0] r_s1_ctrl;
    logic       r_s1_xor;
    logic [7:0] r_s1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid   <= 1'b0;
            r_s1_is_ctrl <= 1'b0;
            r_s1_ctrl    <= 2'b00;
            r_s1_xor     <= 1'b0;
            r_s1_q       <= 8'h00;
        end else begin
            r_s1_valid <= sym_valid_i;
            if (sym_valid_i) begin
                r_s1_is_ctrl <= w_is_ctrl;
                r_s1_ctrl    <= w_ctrl;
                r_s1_xor     <= sym_i[8];
                r_s1_q       <= sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: undo the XOR/XNOR transition chain and register outputs
    // ------------------------------------------------------------------------
    logic [7:0] w_dec;

    always_comb begin
        w_dec    = 8'h00;
        w_dec[0] = r_s1_q[0];
        for (int i = 1; i < 8; i++) begin
            w_dec[i] = r_s1_xor ? (r_s1_q[i] ^ r_s1_q[i-1])
                                : ~(r_s1_q[i] ^ r_s1_q[i-1]);
        end
    end

    logic [7:0] r_data;
    logic [1:0] r_ctrl;
    logic       r_de;
    logic       r_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data  <= 8'h00;
            r_ctrl  <= 2'b00;
            r_de    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_is_ctrl) begin
                    r_data <= 8'h00;
                    r_ctrl <= r_s1_ctrl;
                    r_de   <= 1'b0;
                end else begin
                    r_data <= w_dec;
                    r_de   <= 1'b1;
                end
            end
        end
    end

    assign data_o  = r_data;
    assign ctrl_o  = r_ctrl;
    assign de_o    = r_de;
    assign valid_o = r_valid;

    // ------------------------------------------------------------------------
    // Alignment FSM
    // ------------------------------------------------------------------------
    logic [1:0]          r_state,     w_state_nxt;
    logic [7:0]          r_run,       w_run_nxt;
    logic [c_WIN_W-1:0]  r_win,       w_win_nxt;
    logic [c_SLIP_W-1:0] r_slip,      w_slip_nxt;
    logic                r_locked,    w_locked_nxt;
    logic                r_bitslip,   w_bitslip_nxt;
    logic                r_lock_lost, w_lock_lost_nxt;

    logic [7:0]          w_run_inc;
    logic [c_WIN_W-1:0]  w_win_inc;

    // Both counters saturate so a stalled or pathological stream cannot wrap
    assign w_run_inc = !w_is_ctrl ? 8'h00 : ((&r_run) ? r_run : r_run + 8'd1);
    assign w_win_inc = (&r_win) ? r_win : r_win + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_run_nxt       = r_run;
        w_win_nxt       = r_win;
        w_slip_nxt      = r_slip;
        w_locked_nxt    = r_locked;
        w_bitslip_nxt   = 1'b0;
        w_lock_lost_nxt = 1'b0;

        if (sym_valid_i) begin
            case (r_state)
                c_ST_SEARCH: begin
                    w_run_nxt = w_run_inc;
                    w_win_nxt = w_win_inc;
                    // Lock takes priority over a window expiring on the same symbol
                    if (w_run_inc >= c_LOCK_LIM) begin
                        w_state_nxt  = c_ST_LOCKED;
                        w_win_nxt    = '0;
                        w_locked_nxt = 1'b1;
                    end else if (w_win_inc >= c_WIN_LIM) begin
                        w_state_nxt   = c_ST_SLIP;
                        w_bitslip_nxt = 1'b1;
                        w_slip_nxt    = '0;
                        w_run_nxt     = 8'h00;
                        w_win_nxt     = '0;
                    end
                end
                c_ST_SLIP: begin
                    if (r_slip == c_SLIP_LAST) begin
                        w_state_nxt = c_ST_SEARCH;
                        w_slip_nxt  = '0;
                        w_run_nxt   = 8'h00;
                        w_win_nxt   = '0;
                    end else begin
                        w_slip_nxt = r_slip + 1'b1;
                    end
                end
                c_ST_LOCKED: begin
                    w_run_nxt = w_run_inc;
                    if (w_run_inc >= c_BLANK_MIN) begin
                        w_win_nxt = '0;
                    end else if (w_win_inc >= c_WIN_LIM) begin
                        w_state_nxt     = c_ST_SEARCH;
                        w_locked_nxt    = 1'b0;
                        w_lock_lost_nxt = 1'b1;
                        w_run_nxt       = 8'h00;
                        w_win_nxt       = '0;
                    end else begin
                        w_win_nxt = w_win_inc;
                    end
                end
                default: begin
                    w_state_nxt  = c_ST_SEARCH;
                    w_run_nxt    = 8'h00;
                    w_win_nxt    = '0;
                    w_slip_nxt   = '0;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= c_ST_SEARCH;
            r_run       <= 8'h00;
            r_win       <= '0;
            r_slip      <= '0;
            r_locked    <= 1'b0;
            r_bitslip   <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_win       <= w_win_nxt;
            r_slip      <= w_slip_nxt;
            r_locked    <= w_locked_nxt;
            r_bitslip   <= w_bitslip_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    assign locked_o    = r_locked;
    assign bitslip_o   = r_bitslip;
    assign lock_lost_o = r_lock_lost;

endmodule
`default_nettype wire
